// File: rtl/imem_wait.sv
// Instruction memory for the fetch stage: valid/ready request/response with a fixed
// number of wait states, a word-wide load port, and fault flagging for bad addresses.
//
// state | meaning
// IDLE  | no fetch in flight, ready for a request
// WAIT  | request latched, counting wait states
// RESP  | response held on rsp_* until rsp_ready
module imem_wait #(
  parameter int          DEPTH       = 256,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] NOP_INST    = 32'h0000_0013,
  localparam int         AW          = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [31:0]   req_addr,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_inst,
  output logic          rsp_fault,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_data
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [3:0]    cnt;
  logic [3:0]    cnt_nxt;
  logic          accept;
  logic          capture;
  logic [31:0]   addr_q;
  logic [31:0]   rd_addr;
  logic          rd_fault;
  logic [AW-1:0] rd_idx;
  logic [31:0]   mem [DEPTH];

  assign req_ready = !ld_en && (state == IDLE || (state == RESP && rsp_ready));
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state == RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (WS == 4'd0) begin
            state_nxt = RESP;
            capture   = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = 4'd1;
          end
        end
      end
      WAIT: begin
        if (cnt == WS) begin
          state_nxt = RESP;
          capture   = 1'b1;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          if (accept) begin
            if (WS == 4'd0) begin
              state_nxt = RESP;
              capture   = 1'b1;
            end else begin
              state_nxt = WAIT;
              cnt_nxt   = 4'd1;
            end
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  // With no wait states the read happens on the accept edge, before addr_q is loaded.
  assign rd_addr  = (state == WAIT) ? addr_q : req_addr;
  assign rd_fault = (rd_addr[1:0] != 2'b00) || (rd_addr[31:2] >= 30'(DEPTH));
  assign rd_idx   = rd_addr[AW+1:2];

  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= 32'd0;
      rsp_inst  <= NOP_INST;
      rsp_fault <= 1'b0;
    end else begin
      if (accept) begin
        addr_q <= req_addr;
      end
      if (capture) begin
        rsp_fault <= rd_fault;
        rsp_inst  <= rd_fault ? NOP_INST : mem[rd_idx];
      end
    end
  end

endmodule

// File: tb/tb_imem_wait.sv
// Directed bench for imem_wait: one instance with no wait states (a_*), one with three (b_*).
module tb_imem_wait;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;

  logic        a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready, a_rsp_fault, a_ld_en;
  logic [31:0] a_req_addr, a_rsp_inst, a_ld_data;
  logic [7:0]  a_ld_addr;

  logic        b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready, b_rsp_fault, b_ld_en;
  logic [31:0] b_req_addr, b_rsp_inst, b_ld_data;
  logic [7:0]  b_ld_addr;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  imem_wait #(.DEPTH(256), .WAIT_STATES(0)) u_a (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_addr(a_req_addr),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_inst(a_rsp_inst),
    .rsp_fault(a_rsp_fault), .ld_en(a_ld_en), .ld_addr(a_ld_addr), .ld_data(a_ld_data)
  );

  imem_wait #(.DEPTH(256), .WAIT_STATES(3)) u_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_addr(b_req_addr),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_inst(b_rsp_inst),
    .rsp_fault(b_rsp_fault), .ld_en(b_ld_en), .ld_addr(b_ld_addr), .ld_data(b_ld_data)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_a(input logic [7:0] idx, input logic [31:0] d);
    a_ld_en = 1'b1; a_ld_addr = idx; a_ld_data = d;
    step();
    a_ld_en = 1'b0;
  endtask

  task automatic load_b(input logic [7:0] idx, input logic [31:0] d);
    b_ld_en = 1'b1; b_ld_addr = idx; b_ld_data = d;
    step();
    b_ld_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    #1;
    tests++; if (a_rsp_valid !== 1'b0) begin fails++; $display("FAIL rst_a_valid got %b exp 0", a_rsp_valid); end
    tests++; if (a_rsp_inst !== NOP) begin fails++; $display("FAIL rst_a_inst got %h exp %h", a_rsp_inst, NOP); end
    tests++; if (a_rsp_fault !== 1'b0) begin fails++; $display("FAIL rst_a_fault got %b exp 0", a_rsp_fault); end
    tests++; if (a_req_ready !== 1'b1) begin fails++; $display("FAIL rst_a_ready got %b exp 1", a_req_ready); end
    tests++; if (b_rsp_valid !== 1'b0) begin fails++; $display("FAIL rst_b_valid got %b exp 0", b_rsp_valid); end
    tests++; if (b_rsp_inst !== NOP) begin fails++; $display("FAIL rst_b_inst got %h exp %h", b_rsp_inst, NOP); end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 4; i++) load_a(8'(i), 32'hA000_0000 + 32'(i));
    a_rsp_ready = 1'b1;
    a_req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_req_addr = 32'(i * 4);
      #1;
      tests++; if (a_req_ready !== 1'b1) begin fails++; $display("FAIL stream_ready%0d got %b exp 1", i, a_req_ready); end
      step();
      tests++; if (a_rsp_valid !== 1'b1) begin fails++; $display("FAIL stream_valid%0d got %b exp 1", i, a_rsp_valid); end
      tests++; if (a_rsp_inst !== 32'hA000_0000 + 32'(i)) begin fails++; $display("FAIL stream_inst%0d got %h exp %h", i, a_rsp_inst, 32'hA000_0000 + 32'(i)); end
      tests++; if (a_rsp_fault !== 1'b0) begin fails++; $display("FAIL stream_fault%0d got %b exp 0", i, a_rsp_fault); end
    end
    a_req_valid = 1'b0;
    step();
    tests++; if (a_rsp_valid !== 1'b0) begin fails++; $display("FAIL stream_idle got %b exp 0", a_rsp_valid); end
  endtask

  task automatic test_wait_states();
    load_b(8'd2, 32'hB000_0002);
    b_rsp_ready = 1'b1;
    b_req_valid = 1'b1;
    b_req_addr  = 32'd8;
    #1;
    tests++; if (b_req_ready !== 1'b1) begin fails++; $display("FAIL ws_accept_ready got %b exp 1", b_req_ready); end
    step();
    for (int c = 1; c <= 3; c++) begin
      tests++; if (b_rsp_valid !== 1'b0) begin fails++; $display("FAIL ws_valid_c%0d got %b exp 0", c, b_rsp_valid); end
      tests++; if (b_req_ready !== 1'b0) begin fails++; $display("FAIL ws_ready_c%0d got %b exp 0", c, b_req_ready); end
      if (c == 3) b_req_valid = 1'b0;
      step();
    end
    tests++; if (b_rsp_valid !== 1'b1) begin fails++; $display("FAIL ws_valid_c4 got %b exp 1", b_rsp_valid); end
    tests++; if (b_rsp_inst !== 32'hB000_0002) begin fails++; $display("FAIL ws_inst got %h exp b0000002", b_rsp_inst); end
    tests++; if (b_rsp_fault !== 1'b0) begin fails++; $display("FAIL ws_fault got %b exp 0", b_rsp_fault); end
    step();
    tests++; if (b_rsp_valid !== 1'b0) begin fails++; $display("FAIL ws_done got %b exp 0", b_rsp_valid); end
  endtask

  task automatic test_backpressure();
    load_a(8'd5, 32'hC000_0005);
    load_a(8'd6, 32'hC000_0006);
    a_rsp_ready = 1'b0;
    a_req_valid = 1'b1;
    a_req_addr  = 32'd20;
    step();
    a_req_addr = 32'd24;
    for (int c = 0; c < 5; c++) begin
      #1;
      tests++; if (a_rsp_valid !== 1'b1) begin fails++; $display("FAIL bp_valid%0d got %b exp 1", c, a_rsp_valid); end
      tests++; if (a_rsp_inst !== 32'hC000_0005) begin fails++; $display("FAIL bp_inst%0d got %h exp c0000005", c, a_rsp_inst); end
      tests++; if (a_req_ready !== 1'b0) begin fails++; $display("FAIL bp_ready%0d got %b exp 0", c, a_req_ready); end
      step();
    end
    a_rsp_ready = 1'b1;
    #1;
    tests++; if (a_req_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready got %b exp 1", a_req_ready); end
    step();
    a_req_valid = 1'b0;
    tests++; if (a_rsp_inst !== 32'hC000_0006) begin fails++; $display("FAIL bp_next_inst got %h exp c0000006", a_rsp_inst); end
    step();
  endtask

  task automatic test_faults();
    int n;
    b_rsp_ready = 1'b1;
    b_req_valid = 1'b1;
    b_req_addr  = 32'h6;
    step();
    b_req_valid = 1'b0;
    n = 1;
    while (!b_rsp_valid && n < 20) begin step(); n++; end
    tests++; if (n !== 4) begin fails++; $display("FAIL fault_mis_latency got %0d exp 4", n); end
    tests++; if (b_rsp_fault !== 1'b1) begin fails++; $display("FAIL fault_mis_flag got %b exp 1", b_rsp_fault); end
    tests++; if (b_rsp_inst !== NOP) begin fails++; $display("FAIL fault_mis_inst got %h exp %h", b_rsp_inst, NOP); end
    step();
    a_rsp_ready = 1'b1;
    a_req_valid = 1'b1;
    a_req_addr  = 32'd1024;
    step();
    a_req_valid = 1'b0;
    n = 1;
    while (!a_rsp_valid && n < 20) begin step(); n++; end
    tests++; if (n !== 1) begin fails++; $display("FAIL fault_oor_latency got %0d exp 1", n); end
    tests++; if (a_rsp_fault !== 1'b1) begin fails++; $display("FAIL fault_oor_flag got %b exp 1", a_rsp_fault); end
    tests++; if (a_rsp_inst !== NOP) begin fails++; $display("FAIL fault_oor_inst got %h exp %h", a_rsp_inst, NOP); end
    step();
  endtask

  task automatic test_load_collision();
    int n;
    a_req_valid = 1'b1;
    a_req_addr  = 32'd36;
    a_ld_en = 1'b1; a_ld_addr = 8'd9; a_ld_data = 32'hD000_0009;
    #1;
    tests++; if (a_req_ready !== 1'b0) begin fails++; $display("FAIL coll_ready got %b exp 0", a_req_ready); end
    step();
    a_ld_en = 1'b0;
    tests++; if (a_rsp_valid !== 1'b0) begin fails++; $display("FAIL coll_no_accept got %b exp 0", a_rsp_valid); end
    step();
    a_req_valid = 1'b0;
    tests++; if (a_rsp_inst !== 32'hD000_0009) begin fails++; $display("FAIL coll_loaded got %h exp d0000009", a_rsp_inst); end
    step();

    load_b(8'd7, 32'hE000_0000);
    b_rsp_ready = 1'b1;
    b_req_valid = 1'b1;
    b_req_addr  = 32'd28;
    step();
    b_req_valid = 1'b0;
    step();
    step();
    b_ld_en = 1'b1; b_ld_addr = 8'd7; b_ld_data = 32'hE000_0001;
    step();
    b_ld_en = 1'b0;
    tests++; if (b_rsp_valid !== 1'b1) begin fails++; $display("FAIL coll_b_valid got %b exp 1", b_rsp_valid); end
    tests++; if (b_rsp_inst !== 32'hE000_0000) begin fails++; $display("FAIL coll_b_old got %h exp e0000000", b_rsp_inst); end
    step();
    b_req_valid = 1'b1;
    step();
    b_req_valid = 1'b0;
    n = 1;
    while (!b_rsp_valid && n < 20) begin step(); n++; end
    tests++; if (b_rsp_inst !== 32'hE000_0001) begin fails++; $display("FAIL coll_b_new got %h exp e0000001", b_rsp_inst); end
    step();
  endtask

  task automatic test_reset_in_wait();
    int n;
    b_rsp_ready = 1'b1;
    b_req_valid = 1'b1;
    b_req_addr  = 32'd8;
    step();
    b_req_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests++; if (b_rsp_valid !== 1'b0) begin fails++; $display("FAIL rw_valid got %b exp 0", b_rsp_valid); end
    tests++; if (b_rsp_inst !== NOP) begin fails++; $display("FAIL rw_inst got %h exp %h", b_rsp_inst, NOP); end
    tests++; if (b_req_ready !== 1'b1) begin fails++; $display("FAIL rw_ready got %b exp 1", b_req_ready); end
    repeat (4) step();
    tests++; if (b_rsp_valid !== 1'b0) begin fails++; $display("FAIL rw_dropped got %b exp 0", b_rsp_valid); end
    b_req_valid = 1'b1;
    step();
    b_req_valid = 1'b0;
    n = 1;
    while (!b_rsp_valid && n < 20) begin step(); n++; end
    tests++; if (n !== 4) begin fails++; $display("FAIL rw_latency got %0d exp 4", n); end
    tests++; if (b_rsp_inst !== 32'hB000_0002) begin fails++; $display("FAIL rw_refetch got %h exp b0000002", b_rsp_inst); end
    step();
  endtask

  initial begin
    rst = 1'b1;
    a_req_valid = 1'b0; a_req_addr = 32'd0; a_rsp_ready = 1'b0;
    a_ld_en = 1'b0; a_ld_addr = 8'd0; a_ld_data = 32'd0;
    b_req_valid = 1'b0; b_req_addr = 32'd0; b_rsp_ready = 1'b0;
    b_ld_en = 1'b0; b_ld_addr = 8'd0; b_ld_data = 32'd0;
    test_reset();
    test_stream();
    test_wait_states();
    test_backpressure();
    test_faults();
    test_load_collision();
    test_reset_in_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
